// File: rtl/clk_div_prog.sv
// clk_div_prog
// Programmable clock-enable divider. It produces a registered divided clock
// (clk_out) and a one-cycle period-start pulse (tick) from clk_in. The divide
// ratio and high time are captured into a shadow register by 'load'. They are
// promoted to the active set only at a period boundary (the wrap) or while the
// divider is disabled, so a period is never shortened or stretched.
//
// Parameters:
//   CNT_W    width of the counter, div_ratio and high_cnt
//   DEF_DIV  divide ratio after reset (2 .. 2^CNT_W-1)
//   DEF_HIGH high cycles per period after reset (0 .. DEF_DIV)
//
// Ports:
//   clk_in      system clock, rising edge
//   rst         asynchronous active-high reset
//   en          divider enable
//   load        one-cycle strobe capturing div_ratio/high_cnt
//   div_ratio   requested period N in clk_in cycles
//   high_cnt    requested high cycles H per period
//   clk_out     registered divided clock
//   tick        registered pulse on the first cycle of each period
//   cfg_pending a captured configuration is waiting for a boundary
//   cfg_err     sticky: the last load had div_ratio < 2
module clk_div_prog #(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 8,
  parameter int DEF_HIGH = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic [CNT_W-1:0] high_cnt,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_act_n;
  logic [CNT_W-1:0] r_act_h;
  logic [CNT_W-1:0] r_pend_n;
  logic [CNT_W-1:0] r_pend_h;
  logic             r_pend_valid;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_cfg_err;

  logic w_wrap;
  logic w_div_ok;
  logic w_load_ok;
  logic w_apply;

  // The last cycle of the period. cnt never exceeds act_n-1, so an equality
  // test is enough.
  assign w_wrap    = en & (r_cnt == (r_act_n - ONE));
  assign w_div_ok  = (div_ratio >= TWO);
  assign w_load_ok = load & w_div_ok;
  // The shadow is promoted at a period boundary, or at once while disabled
  // because no period is running then.
  assign w_apply   = r_pend_valid & (~en | w_wrap);

  // Period counter. Holding it at zero while disabled means that a re-enable
  // always starts a fresh, full-length period.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // Active and shadow configuration. When a load coincides with an apply, the
  // apply takes the old shadow contents and the new values replace them, so
  // pend_valid stays set.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_act_n      <= DEF_N;
      r_act_h      <= DEF_H;
      r_pend_n     <= DEF_N;
      r_pend_h     <= DEF_H;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_n <= r_pend_n;
        r_act_h <= r_pend_h;
      end
      if (w_load_ok) begin
        r_pend_n     <= div_ratio;
        r_pend_h     <= high_cnt;
        r_pend_valid <= 1'b1;
      end else if (w_apply) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Sticky error flag. Every load updates it, and only a rejected load sets it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
    end else if (load) begin
      r_cfg_err <= ~w_div_ok;
    end
  end

  // Registered outputs are decoded from the pre-update count and high time.
  // This gives glitch-free outputs that lag the counter by one cycle. H=0 gives
  // constant low and H>=N gives constant high.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_clk_out <= en & (r_cnt < r_act_h);
      r_tick    <= en & (r_cnt == '0);
    end
  end

  assign clk_out     = r_clk_out;
  assign tick        = r_tick;
  assign cfg_pending = r_pend_valid;
  assign cfg_err     = r_cfg_err;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable, parametrised clock-enable divider that generates a divided clock output and a period-start tick from the system clock. Divide ratio and high time are run-time programmable through a shadow register and take effect only at a period boundary, so clk_out never glitches or shortens a period. It replaces the fixed divide-by-8, 50 % duty divider. Downstream logic consumes tick as a clock enable; clk_out is for observation and external pins.

## Interface

Parameters:
- CNT_W, 8: width of the counter, div_ratio and high_cnt.
- DEF_DIV, 8: divide ratio loaded at reset. Legal range 2 .. 2^CNT_W-1.
- DEF_HIGH, 4: high-time cycles loaded at reset. Legal range 0 .. DEF_DIV.

Ports (one clock; reset is asynchronous and active-high):
- clk_in  in  1  system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  divider enable.
- load  in  1  single-cycle strobe that captures div_ratio/high_cnt.
- div_ratio  in  CNT_W  requested period in clk_in cycles (N).
- high_cnt  in  CNT_W  requested high cycles per period (H).
- clk_out  out  1  registered divided clock.
- tick  out  1  registered one-cycle pulse on the first cycle of each period.
- cfg_pending  out  1  a loaded configuration is waiting for the next boundary.
- cfg_err  out  1  sticky flag: last load had div_ratio < 2.

## Operation

- Internal state: counter cnt, active registers act_n/act_h, shadow registers pend_n/pend_h, and pend_valid (drives cfg_pending).
- Reset: cnt=0, act_n=DEF_DIV, act_h=DEF_HIGH, pend_valid=0, clk_out=0, tick=0, cfg_err=0.
- When load=1 and div_ratio>=2: pend_n<=div_ratio, pend_h<=high_cnt, pend_valid<=1, cfg_err<=0. A new load overwrites an earlier pending one.
- When load=1 and div_ratio<2: shadow and pend_valid are unchanged, and cfg_err<=1.
- When en=1 and cnt==act_n-1 (wrap): cnt<=0. If pend_valid, act<=pend and pend_valid<=0.
- When en=1 and not at wrap: cnt<=cnt+1.
- When en=0: cnt<=0. Any pending configuration is applied immediately (act<=pend, pend_valid<=0).
- Load in the same cycle as a wrap or en=0 apply: the old shadow is applied, the new values are captured into the shadow, and pend_valid ends at 1.
- clk_out<=en & (cnt<act_h), evaluated on the current cnt and act_h.
  - H=0 gives constant 0.
  - H>=N gives constant 1 while enabled.
- tick<=en & (cnt==0).
- Counter arithmetic is unsigned CNT_W-bit. cnt never exceeds act_n-1, so no overflow path exists.

## Timing

- clk_out and tick lag cnt by one cycle and are always glitch-free register outputs.
- First tick arrives one cycle after the first enabled cycle. clk_out rises together with tick when H>0.
- Period is exactly act_n cycles with exactly act_h high cycles (H<=N). There are no short or stretched periods across a reconfiguration.
- New configuration latency:
  - The first cycle of the new period uses it at the cnt level.
  - It is visible on clk_out/tick one cycle later.
- cfg_pending is set the cycle after load and cleared the cycle after the applying wrap or en=0.
- en falling: clk_out and tick are 0 from the next edge.
- en rising: cnt starts at 0, with tick one cycle later.
- rst asserted mid-period: all outputs clear asynchronously, and a pending configuration is discarded.

## Test plan

- Reset defaults: release rst, en=1 -> tick every 8 cycles; clk_out high 4 cycles, low 4 cycles; cfg_pending=0, cfg_err=0.
- Reconfigure mid-period: load N=5, H=2 at cnt=3 -> current 8-cycle period completes unchanged, then periods are 5 cycles with 2 high; cfg_pending is high until the boundary.
- Edge ratios:
  - N=2, H=1 -> clk_out toggles every cycle, tick every 2 cycles.
  - N=3, H=0 -> clk_out constant 0, tick every 3 cycles.
  - N=3, H=5 -> clk_out constant 1.
- Illegal load: load N=1 -> cfg_err=1 and the active period is unchanged. A following load with N=6 clears cfg_err.
- Enable and load collision:
  - Drop en for 3 cycles with a pending N=4 -> outputs 0; after en returns, periods are 4 cycles.
  - Load on the wrap cycle -> old pending is applied, new load is pending.
- Async reset mid-operation: assert rst between clock edges with N=10 pending -> outputs 0 immediately; after release, period is 8 and the pending configuration is lost.
